// File: rtl/sme_share_sequencer.sv
// Share sequencer around the SME ALU: reads rs1/rs2 shares from the share
// bank one index per cycle, hands the full share arrays to the ALU with a
// valid/ready handshake, writes the rd shares back one index per cycle and
// pulses issue_done on the last write-back cycle.
// Ports: g_clk/g_reset (sync, active-high), flush; issue_* pipeline side;
// sh_rd_*/sh_wr_* share bank side; alu_* ALU side.
// Option: define SME_SEQ_SCRUB_EN to zero operand/result shares once used
// and to mask alu_rs1/alu_rs2 while alu_valid is low.
module sme_share_sequencer #(
  parameter int XLEN = 32,
  parameter int SMAX = 4,
  localparam int SW = (SMAX > 1) ? $clog2(SMAX) : 1
) (
  input  logic                      g_clk,
  input  logic                      g_reset,
  input  logic                      flush,
  input  logic [3:0]                smectl_d,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [4:0]                issue_rs1,
  input  logic [4:0]                issue_rs2,
  input  logic [4:0]                issue_rd,
  output logic                      issue_done,
  output logic                      sh_rd_en,
  output logic [SW-1:0]             sh_rd_idx,
  output logic [4:0]                sh_rs1_addr,
  output logic [4:0]                sh_rs2_addr,
  input  logic [XLEN-1:0]           sh_rs1_rdata,
  input  logic [XLEN-1:0]           sh_rs2_rdata,
  output logic                      sh_wr_en,
  output logic [SW-1:0]             sh_wr_idx,
  output logic [4:0]                sh_wr_addr,
  output logic [XLEN-1:0]           sh_wr_data,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  output logic                      alu_flush,
  output logic [SMAX-1:0][XLEN-1:0] alu_rs1,
  output logic [SMAX-1:0][XLEN-1:0] alu_rs2,
  input  logic [SMAX-1:0][XLEN-1:0] alu_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             cnt_q, cnt_d;
  logic [SW-1:0]             last_q, last_d;
  logic [4:0]                rs1_q, rs2_q, rd_q;
  logic [SMAX-1:0][XLEN-1:0] op1_q, op2_q, res_q;

  logic kill, accept, cnt_last, hs, busy;

  // Reset mid-operation behaves like a flush on the outputs.
  assign kill        = flush | g_reset;
  assign busy        = (state_q != IDLE);
  assign issue_ready = (state_q == IDLE) && !g_reset;
  assign accept      = issue_valid && issue_ready && !flush;
  assign cnt_last    = (cnt_q == last_q);
  assign hs          = (state_q == EXEC) && alu_ready && !kill;

  assign sh_rd_idx   = cnt_q;
  assign sh_wr_idx   = cnt_q;
  assign sh_rs1_addr = rs1_q;
  assign sh_rs2_addr = rs2_q;
  assign sh_wr_addr  = rd_q;
  assign sh_wr_data  = res_q[cnt_q];
  assign alu_flush   = flush;

`ifdef SME_SEQ_SCRUB_EN
  assign alu_rs1 = alu_valid ? op1_q : '0;
  assign alu_rs2 = alu_valid ? op2_q : '0;
`else
  assign alu_rs1 = op1_q;
  assign alu_rs2 = op2_q;
`endif

  // Effective share count minus one: clamp(smectl_d, 2, SMAX) - 1.
  always_comb begin
    last_d = SW'(1);
    if (smectl_d < 4'd2)
      last_d = SW'(1);
    else if (int'(smectl_d) > SMAX)
      last_d = SW'(SMAX - 1);
    else
      last_d = SW'(smectl_d - 4'd1);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_rd_en   = 1'b0;
    sh_wr_en   = 1'b0;
    alu_valid  = 1'b0;
    issue_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept)
          state_d = READ;
      end
      READ: begin
        sh_rd_en = !kill;
        if (cnt_last) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        alu_valid = !kill;
        cnt_d     = '0;
        if (alu_ready)
          state_d = WRITE;
      end
      WRITE: begin
        sh_wr_en   = !kill && (rd_q != 5'd0);
        issue_done = !kill && cnt_last;
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (busy && flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      last_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        rs1_q  <= issue_rs1;
        rs2_q  <= issue_rs2;
        rd_q   <= issue_rd;
        last_q <= last_d;
        op1_q  <= '0;
        op2_q  <= '0;
      end
      if (sh_rd_en) begin
        op1_q[cnt_q] <= sh_rs1_rdata;
        op2_q[cnt_q] <= sh_rs2_rdata;
      end
      if (hs)
        res_q <= alu_rd;
`ifdef SME_SEQ_SCRUB_EN
      if (hs) begin
        op1_q <= '0;
        op2_q <= '0;
      end
      if (issue_done || (busy && flush))
        res_q <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_sme_share_sequencer.sv
// Self-checking bench for sme_share_sequencer: directed cases plus random
// operations checked cycle by cycle against an expected transaction trace.
module tb_sme_share_sequencer;
  localparam int XLEN = 32;
  localparam int SMAX = 4;
  localparam int SW   = 2;
  localparam int WW   = XLEN * SMAX;

  logic                      g_clk = 1'b0;
  logic                      g_reset;
  logic                      flush;
  logic [3:0]                smectl_d;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [4:0]                issue_rs1, issue_rs2, issue_rd;
  logic                      issue_done;
  logic                      sh_rd_en;
  logic [SW-1:0]             sh_rd_idx;
  logic [4:0]                sh_rs1_addr, sh_rs2_addr;
  logic [XLEN-1:0]           sh_rs1_rdata, sh_rs2_rdata;
  logic                      sh_wr_en;
  logic [SW-1:0]             sh_wr_idx;
  logic [4:0]                sh_wr_addr;
  logic [XLEN-1:0]           sh_wr_data;
  logic                      alu_valid;
  logic                      alu_ready;
  logic                      alu_flush;
  logic [SMAX-1:0][XLEN-1:0] alu_rs1, alu_rs2, alu_rd;

  logic [XLEN-1:0] bank [32][SMAX];

  int checks = 0;
  int errors = 0;

  assign sh_rs1_rdata = bank[sh_rs1_addr][sh_rd_idx];
  assign sh_rs2_rdata = bank[sh_rs2_addr][sh_rd_idx];

  always #5 g_clk = ~g_clk;

  sme_share_sequencer #(.XLEN(XLEN), .SMAX(SMAX)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .smectl_d(smectl_d), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_done(issue_done), .sh_rd_en(sh_rd_en),
    .sh_rd_idx(sh_rd_idx), .sh_rs1_addr(sh_rs1_addr),
    .sh_rs2_addr(sh_rs2_addr), .sh_rs1_rdata(sh_rs1_rdata),
    .sh_rs2_rdata(sh_rs2_rdata), .sh_wr_en(sh_wr_en),
    .sh_wr_idx(sh_wr_idx), .sh_wr_addr(sh_wr_addr),
    .sh_wr_data(sh_wr_data), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_flush(alu_flush),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  // One operation, starting and ending at a negedge in IDLE.
  // flush_at >= 0 aborts during the read of that share index.
  task automatic run_op(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] smd,
                        input int delay, input int flush_at);
    int d;
    logic [SMAX-1:0][XLEN-1:0] e1, e2, res;
    d = (smd < 2) ? 2 : ((smd > SMAX) ? SMAX : int'(smd));
    for (int k = 0; k < SMAX; k++) begin
      e1[k]  = (k < d) ? bank[rs1][k] : '0;
      e2[k]  = (k < d) ? bank[rs2][k] : '0;
      res[k] = $urandom;
    end
    alu_rd      = res;
    issue_valid = 1'b1;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    smectl_d    = smd;
    #1 chk("issue_ready_idle", WW'(issue_ready), WW'(1));
    step();
    issue_valid = 1'b0;
    smectl_d    = 4'($urandom);
    for (int k = 0; k < d; k++) begin
      alu_ready = 1'($urandom);
      if (k == flush_at) begin
        flush = 1'b1;
        #1;
        chk("flush_alu_valid", WW'(alu_valid), WW'(0));
        chk("flush_wr_en", WW'(sh_wr_en), WW'(0));
        chk("flush_done", WW'(issue_done), WW'(0));
        chk("flush_alu_flush", WW'(alu_flush), WW'(1));
        step();
        flush = 1'b0;
        #1;
        chk("flush_ready", WW'(issue_ready), WW'(1));
        chk("flush_no_rd", WW'(sh_rd_en), WW'(0));
        chk("flush_no_valid", WW'(alu_valid), WW'(0));
        return;
      end
      #1;
      chk("rd_en", WW'(sh_rd_en), WW'(1));
      chk("rd_idx", WW'(sh_rd_idx), WW'(k));
      chk("rs1_addr", WW'(sh_rs1_addr), WW'(rs1));
      chk("rs2_addr", WW'(sh_rs2_addr), WW'(rs2));
      chk("rd_no_valid", WW'(alu_valid), WW'(0));
      chk("rd_busy", WW'(issue_ready), WW'(0));
      step();
    end
    for (int w = 0; w <= delay; w++) begin
      alu_ready = (w == delay);
      #1;
      chk("exec_valid", WW'(alu_valid), WW'(1));
      chk("exec_rs1", alu_rs1, e1);
      chk("exec_rs2", alu_rs2, e2);
      chk("exec_no_wr", WW'(sh_wr_en), WW'(0));
      step();
    end
    alu_rd = WW'({$urandom, $urandom, $urandom, $urandom});
`ifdef SME_SEQ_SCRUB_EN
    chk("scrub_rs1", alu_rs1, '0);
    chk("scrub_op1", dut.op1_q, '0);
`else
    chk("stale_rs1", alu_rs1, e1);
    chk("stale_op1", dut.op1_q, e1);
`endif
    for (int k = 0; k < d; k++) begin
      alu_ready = 1'($urandom);
      #1;
      chk("wr_en", WW'(sh_wr_en), WW'(rd != 5'd0));
      chk("wr_idx", WW'(sh_wr_idx), WW'(k));
      chk("wr_addr", WW'(sh_wr_addr), WW'(rd));
      chk("wr_data", WW'(sh_wr_data), WW'(res[k]));
      chk("done", WW'(issue_done), WW'(k == d - 1));
      chk("wr_no_valid", WW'(alu_valid), WW'(0));
      step();
    end
    alu_ready = 1'b0;
    #1;
    chk("done_clear", WW'(issue_done), WW'(0));
    chk("back_idle", WW'(issue_ready), WW'(1));
  endtask

  initial begin
    g_reset     = 1'b1;
    flush       = 1'b0;
    smectl_d    = 4'd0;
    issue_valid = 1'b0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_rd    = '0;
    alu_ready   = 1'b0;
    alu_rd      = '0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < SMAX; k++)
        bank[r][k] = $urandom;
    bank[5][0] = 32'hAAAA_0001;
    bank[5][1] = 32'hBBBB_0002;
    bank[6][0] = 32'hCCCC_0003;
    bank[6][1] = 32'hDDDD_0004;

    @(negedge g_clk);
    step();
    #1;
    chk("rst_ready", WW'(issue_ready), WW'(0));
    chk("rst_valid", WW'(alu_valid), WW'(0));
    chk("rst_rd_en", WW'(sh_rd_en), WW'(0));
    chk("rst_wr_en", WW'(sh_wr_en), WW'(0));
    chk("rst_done", WW'(issue_done), WW'(0));
    chk("rst_rs1", alu_rs1, '0);
    g_reset = 1'b0;
    step();

    run_op(5'd5, 5'd6, 5'd7, 4'd2, 0, -1);
    run_op(5'd5, 5'd6, 5'd7, 4'd9, 0, -1);
    run_op(5'd5, 5'd6, 5'd7, 4'd0, 0, -1);
    run_op(5'd5, 5'd6, 5'd9, 4'd3, 3, -1);
    run_op(5'd1, 5'd2, 5'd0, 4'd3, 0, -1);
    run_op(5'd5, 5'd6, 5'd7, 4'd4, 0, 1);
    run_op(5'd3, 5'd4, 5'd8, 4'd2, 1, -1);

    // Flush in IDLE blocks the accept for that cycle.
    issue_valid = 1'b1;
    flush       = 1'b1;
    smectl_d    = 4'd2;
    step();
    issue_valid = 1'b0;
    flush       = 1'b0;
    #1;
    chk("idle_flush_ready", WW'(issue_ready), WW'(1));
    chk("idle_flush_no_rd", WW'(sh_rd_en), WW'(0));

    // Reset mid-operation aborts and clears the holding regs.
    issue_valid = 1'b1;
    issue_rs1   = 5'd5;
    issue_rs2   = 5'd6;
    issue_rd    = 5'd7;
    smectl_d    = 4'd2;
    step();
    issue_valid = 1'b0;
    step();
    step();
    g_reset = 1'b1;
    #1;
    chk("rst_mid_valid", WW'(alu_valid), WW'(0));
    chk("rst_mid_ready", WW'(issue_ready), WW'(0));
    step();
    g_reset = 1'b0;
    #1;
    chk("rst_mid_idle", WW'(issue_ready), WW'(1));
    chk("rst_mid_rs1", alu_rs1, '0);
    chk("rst_mid_rs2", alu_rs2, '0);

    for (int i = 0; i < 20; i++) begin
      int fa;
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      run_op(5'($urandom), 5'($urandom), 5'($urandom_range(0, 3)),
             4'($urandom), int'($urandom_range(0, 3)), fa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
